mips_multicycle_ctrl: RTL

- Multicycle MIPS control unit: the FSM that produces the 3-bit aluControl code consumed by the ALU datapath, plus all datapath enables and mux selects.
- Sits between the instruction register (opcode, funct) and the datapath.
- Consumes the ALU zero flag for branch resolution.
- Moore FSM for enables and selects; aluControl decoded from ALU-op class and funct.

---
 rtl/mips_multicycle_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control unit for a multicycle MIPS datapath. A Moore FSM steps each
// instruction through FETCH/DECODE and its execute and writeback states. It
// drives every datapath enable and mux select, and it derives the 3-bit ALU
// operation code from the state's ALU-op class and the funct field.
//
// Parameters:
//   ILLEGAL_TRAP   1 = an unknown opcode parks the FSM in TRAP until reset
//                  0 = an unknown opcode is treated as a NOP (back to FETCH)
//
// Optional feature macro:
//   MIPS_CTRL_BNE_EN   when defined, opcode 000101 (bne) is decoded and the
//                      branch is taken on zero == 0; when undefined, bne is
//                      an illegal opcode
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset; also forces all outputs to 0
//   opcode      instr[31:26], valid from DECODE onward
//   funct       instr[5:0]
//   zero        ALU zero flag, used for branch resolution
//   iorD        memory address select (0 = PC, 1 = ALUOut)
//   memWrite    data memory write enable
//   irWrite     instruction register load
//   regDst      write-register select (0 = rt, 1 = rd)
//   memToReg    write-back select (1 = memory data)
//   regWrite    register file write enable
//   aluSrcA     ALU A select (0 = PC, 1 = rs)
//   aluSrcB     ALU B select (00 rt, 01 4, 10 signImm, 11 signImm<<2)
//   aluControl  ALU operation code
//   pcSrc       next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   pcEn        PC load enable
//   illegal     high while the FSM sits in TRAP
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iorD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [1:0] pcSrc,
    output logic       pcEn,
    output logic       illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;
    localparam logic [2:0] ALUC_UND = 3'b011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_NONE  = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2,
        ALU_FUNCT = 2'd3
    } alu_op_t;

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    pc_write;
    logic    branch;
    logic    branch_ne;

`ifdef MIPS_CTRL_BNE_EN
    // Remembers whether the branch in flight is bne, captured in DECODE so
    // that BRANCH does not depend on the opcode staying put.
    logic bne_q, bne_d;
`endif

    // Next-state logic. Each instruction class follows a fixed path and
    // every path ends back in FETCH, except TRAP, which only reset leaves.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        if (ILLEGAL_TRAP != 0) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

`ifdef MIPS_CTRL_BNE_EN
    // Latch the bne flag as the instruction leaves DECODE.
    always_comb begin
        bne_d = bne_q;
        if (state_q == S_DECODE) begin
            bne_d = (opcode == OP_BNE);
        end
    end
`endif

    // State register with synchronous active-low reset. A reset in the
    // middle of an instruction simply abandons it and restarts at FETCH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
`ifdef MIPS_CTRL_BNE_EN
            bne_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MIPS_CTRL_BNE_EN
            bne_q   <= bne_d;
`endif
        end
    end

    // Moore output decode. States that leave aluControl unused still present
    // ADD so that the ALU never sees a stale or undefined code. Holding rst_n
    // low zeroes every output, so no write or PC update can leak out of an
    // abandoned instruction.
    always_comb begin
        iorD       = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        pcSrc      = 2'b00;
        illegal    = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        alu_op     = ALU_NONE;
        aluControl = ALUC_ADD;
        pcEn       = 1'b0;

        case (state_q)
            S_FETCH: begin
                irWrite  = 1'b1;
                pc_write = 1'b1;
                aluSrcB  = 2'b01;
                alu_op   = ALU_ADD;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                alu_op  = ALU_ADD;
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                alu_op  = ALU_ADD;
            end
            S_MEMRD: begin
                iorD = 1'b1;
            end
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
            end
            S_MEMWR: begin
                iorD     = 1'b1;
                memWrite = 1'b1;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                alu_op  = ALU_FUNCT;
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                alu_op  = ALU_SUB;
                pcSrc   = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
                branch    = ~bne_q;
                branch_ne = bne_q;
`else
                branch    = 1'b1;
`endif
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                alu_op  = ALU_ADD;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
            end
            S_JUMP: begin
                pcSrc    = 2'b10;
                pc_write = 1'b1;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase

        case (alu_op)
            ALU_ADD: aluControl = ALUC_ADD;
            ALU_SUB: aluControl = ALUC_SUB;
            ALU_FUNCT: begin
                case (funct)
                    6'b100000: aluControl = ALUC_ADD;
                    6'b100010: aluControl = ALUC_SUB;
                    6'b100100: aluControl = ALUC_AND;
                    6'b100101: aluControl = ALUC_OR;
                    6'b101010: aluControl = ALUC_SLT;
                    default:   aluControl = ALUC_UND;
                endcase
            end
            default: aluControl = ALUC_ADD;
        endcase

        // zero only matters here, so this is the one path from zero to an
        // output.
        pcEn = pc_write | (branch & zero) | (branch_ne & ~zero);

        if (!rst_n) begin
            iorD       = 1'b0;
            memWrite   = 1'b0;
            irWrite    = 1'b0;
            regDst     = 1'b0;
            memToReg   = 1'b0;
            regWrite   = 1'b0;
            aluSrcA    = 1'b0;
            aluSrcB    = 2'b00;
            aluControl = 3'b000;
            pcSrc      = 2'b00;
            pcEn       = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule
